// File: rtl/bcd_time_counter.sv
// BCD hh:mm:ss time-of-day counter advanced by a synchronised 1 Hz square wave.
// Optional alarm comparator enabled by defining BCD_ALARM_EN.
module bcd_time_counter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOUR_MAX    = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_1s,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
`ifdef BCD_ALARM_EN
    input  logic       alarm_set,
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_min,
    input  logic       alarm_ack,
`endif
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       tick_1hz,
    output logic       day_wrap,
    output logic       load_err,
    output logic       alarm
);

    localparam logic [7:0] HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
    localparam logic [7:0] MAX_59       = 8'h59;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tick_q;
    logic [7:0]             hour_q, min_q, sec_q;
    logic [7:0]             hour_d, min_d, sec_d;
    logic                   wrap_q, wrap_d;
    logic                   err_q, err_d;
    logic                   cnt_en_c;
    logic                   alarm_err_c;

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    // A load in the same cycle as a tick consumes that tick.
    assign cnt_en_c = run && tick_q && !load;

    // Next time value: load, or full ripple of the BCD carries in one step.
    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        wrap_d = 1'b0;
        err_d  = alarm_err_c;
        if (load) begin
            if (bcd_ok(set_hour, HOUR_MAX_BCD) && bcd_ok(set_min, MAX_59) && bcd_ok(set_sec, MAX_59)) begin
                hour_d = set_hour;
                min_d  = set_min;
                sec_d  = set_sec;
            end else begin
                err_d = 1'b1;
            end
        end else if (cnt_en_c) begin
            sec_d = (sec_q == MAX_59) ? 8'h00 : bcd_inc(sec_q);
            if (sec_q == MAX_59) begin
                min_d = (min_q == MAX_59) ? 8'h00 : bcd_inc(min_q);
                if (min_q == MAX_59) begin
                    if (hour_q == HOUR_MAX_BCD) begin
                        hour_d = 8'h00;
                        wrap_d = 1'b1;
                    end else begin
                        hour_d = bcd_inc(hour_q);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            tick_q <= 1'b0;
            hour_q <= 8'h00;
            min_q  <= 8'h00;
            sec_q  <= 8'h00;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_1s};
            // Registered rising edge of the last synchroniser stage.
            tick_q <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
            hour_q <= hour_d;
            min_q  <= min_d;
            sec_q  <= sec_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

`ifdef BCD_ALARM_EN
    logic [7:0] al_hour_q, al_min_q;
    logic       armed_q, alarm_q;
    logic       al_ok_c, al_hit_c;

    assign al_ok_c     = bcd_ok(alarm_hour, HOUR_MAX_BCD) && bcd_ok(alarm_min, MAX_59);
    assign alarm_err_c = alarm_set && !al_ok_c;
    // Only counting can fire the alarm; a load landing on the alarm time cannot.
    assign al_hit_c    = cnt_en_c && armed_q && (hour_d == al_hour_q) &&
                         (min_d == al_min_q) && (sec_d == 8'h00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            al_hour_q <= 8'h00;
            al_min_q  <= 8'h00;
            armed_q   <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            if (alarm_set && al_ok_c) begin
                al_hour_q <= alarm_hour;
                al_min_q  <= alarm_min;
                armed_q   <= 1'b1;
            end
            if (al_hit_c) begin
                alarm_q <= 1'b1;
            end else if (alarm_ack) begin
                alarm_q <= 1'b0;
            end
        end
    end

    assign alarm = alarm_q;
`else
    assign alarm_err_c = 1'b0;
    assign alarm       = 1'b0;
`endif

    assign hour_bcd = hour_q;
    assign min_bcd  = min_q;
    assign sec_bcd  = sec_q;
    assign tick_1hz = tick_q;
    assign day_wrap = wrap_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: directed scenarios plus randomized traffic against a
// seconds-of-day reference model. Alarm scenarios compile in with BCD_ALARM_EN.
module tb_bcd_time_counter;

    localparam int S   = 2;
    localparam int HM  = 23;
    localparam int DAY = (HM + 1) * 3600;

    logic       clk, reset, clk_1s, run, load;
    logic [7:0] set_hour, set_min, set_sec;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic       tick_1hz, day_wrap, load_err, alarm;
`ifdef BCD_ALARM_EN
    logic       alarm_set, alarm_ack;
    logic [7:0] alarm_hour, alarm_min;
    bit         armed_m;
    int         al_secs_m;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    int secs_m;
    bit tick_m, wrap_m, err_m, alarm_m;
    bit hist[$];
    int tick_cnt, wrap_cnt;

    bcd_time_counter #(.SYNC_STAGES(S), .HOUR_MAX(HM)) dut (
        .clk(clk), .reset(reset), .clk_1s(clk_1s), .run(run), .load(load),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
`ifdef BCD_ALARM_EN
        .alarm_set(alarm_set), .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_ack(alarm_ack),
`endif
        .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .tick_1hz(tick_1hz), .day_wrap(day_wrap), .load_err(load_err), .alarm(alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bcd_val(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic bit valid_bcd(input logic [7:0] v, input int maxv);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bcd_val(v) <= maxv);
    endfunction

    function automatic bit sampled(input int back);
        if (hist.size() > back) return hist[hist.size() - 1 - back];
        return 1'b0;
    endfunction

    task automatic model_clear();
        secs_m  = 0;
        tick_m  = 0;
        wrap_m  = 0;
        err_m   = 0;
        alarm_m = 0;
        hist.delete();
`ifdef BCD_ALARM_EN
        armed_m   = 0;
        al_secs_m = 0;
`endif
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_hour"}, hour_bcd, to_bcd(secs_m / 3600));
        check_eq({tag, "_min"},  min_bcd,  to_bcd((secs_m / 60) % 60));
        check_eq({tag, "_sec"},  sec_bcd,  to_bcd(secs_m % 60));
        check_eq({tag, "_tick"}, tick_1hz, tick_m);
        check_eq({tag, "_wrap"}, day_wrap, wrap_m);
        check_eq({tag, "_err"},  load_err, err_m);
        check_eq({tag, "_alarm"}, alarm,   alarm_m);
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic cycle();
        bit fire;
        @(posedge clk);
        fire   = 0;
        err_m  = 0;
        wrap_m = 0;
        if (load) begin
            if (valid_bcd(set_hour, HM) && valid_bcd(set_min, 59) && valid_bcd(set_sec, 59))
                secs_m = bcd_val(set_hour) * 3600 + bcd_val(set_min) * 60 + bcd_val(set_sec);
            else
                err_m = 1;
        end else if (run && tick_m) begin
            secs_m = (secs_m + 1) % DAY;
            wrap_m = (secs_m == 0);
`ifdef BCD_ALARM_EN
            fire = armed_m && (secs_m == al_secs_m);
`endif
        end
`ifdef BCD_ALARM_EN
        if (alarm_set) begin
            if (valid_bcd(alarm_hour, HM) && valid_bcd(alarm_min, 59)) begin
                armed_m   = 1;
                al_secs_m = bcd_val(alarm_hour) * 3600 + bcd_val(alarm_min) * 60;
            end else begin
                err_m = 1;
            end
        end
        if (fire) alarm_m = 1;
        else if (alarm_ack) alarm_m = 0;
`else
        if (fire) alarm_m = 1;
`endif
        hist.push_back(clk_1s);
        if (hist.size() > 8) void'(hist.pop_front());
        // A rising sample becomes visible as a tick S-1 edges later.
        tick_m = sampled(S - 1) && !sampled(S);
        #1;
        check_outputs("cyc");
        if (tick_1hz) tick_cnt++;
        if (day_wrap) wrap_cnt++;
    endtask

    task automatic pulse_1s(input int hi, input int lo);
        clk_1s = 1'b1;
        repeat (hi) cycle();
        clk_1s = 1'b0;
        repeat (lo) cycle();
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        load = 1'b1; set_hour = h; set_min = m; set_sec = s;
        cycle();
        load = 1'b0;
    endtask

    task automatic apply_reset();
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int ph;
        reset = 1'b1; clk_1s = 1'b0; run = 1'b0; load = 1'b0;
        set_hour = 8'h00; set_min = 8'h00; set_sec = 8'h00;
`ifdef BCD_ALARM_EN
        alarm_set = 1'b0; alarm_ack = 1'b0; alarm_hour = 8'h00; alarm_min = 8'h00;
`endif
        model_clear();
        tick_cnt = 0; wrap_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        reset = 1'b0;

        // 1: sixty seconds make a minute
        run = 1'b1;
        tick_cnt = 0;
        repeat (60) pulse_1s(3, 3);
        check_eq("t1_sec", sec_bcd, 8'h00);
        check_eq("t1_min", min_bcd, 8'h01);
        check_eq("t1_ticks", tick_cnt, 60);

        // 2: day wrap with exact latency
        do_load(8'h23, 8'h59, 8'h59);
        wrap_cnt = 0;
        clk_1s = 1'b1;
        cycle();
        check_eq("t2_hold0", sec_bcd, 8'h59);
        cycle();
        check_eq("t2_tick", tick_1hz, 1);
        check_eq("t2_hold1", sec_bcd, 8'h59);
        cycle();
        check_eq("t2_hour", hour_bcd, 8'h00);
        check_eq("t2_sec", sec_bcd, 8'h00);
        check_eq("t2_wrap", day_wrap, 1);
        clk_1s = 1'b0;
        repeat (3) cycle();
        check_eq("t2_wrapcnt", wrap_cnt, 1);

        // 3: rejected loads, then a load colliding with a tick
        do_load(8'h12, 8'h34, 8'h5A);
        check_eq("t3_err_sec", load_err, 1);
        check_eq("t3_keep_sec", sec_bcd, 8'h00);
        do_load(8'h24, 8'h00, 8'h00);
        check_eq("t3_err_hour", load_err, 1);
        check_eq("t3_keep_hour", hour_bcd, 8'h00);
        clk_1s = 1'b1;
        for (int i = 0; i < 10 && !tick_m; i++) cycle();
        check_eq("t3_tick_seen", tick_1hz, 1);
        do_load(8'h12, 8'h34, 8'h56);
        repeat (3) cycle();
        clk_1s = 1'b0;
        repeat (3) cycle();
        check_eq("t3_h", hour_bcd, 8'h12);
        check_eq("t3_m", min_bcd, 8'h34);
        check_eq("t3_s", sec_bcd, 8'h56);

        // 4: paused counting and a long-held high level
        run = 1'b0;
        tick_cnt = 0;
        repeat (5) pulse_1s(3, 3);
        check_eq("t4_ticks", tick_cnt, 5);
        check_eq("t4_frozen", sec_bcd, 8'h56);
        run = 1'b1;
        tick_cnt = 0;
        clk_1s = 1'b1;
        repeat (60) cycle();
        clk_1s = 1'b0;
        repeat (4) cycle();
        check_eq("t4_single", tick_cnt, 1);
        check_eq("t4_sec", sec_bcd, 8'h57);

        // 5: asynchronous reset with a pending edge in the synchroniser
        do_load(8'h07, 8'h08, 8'h09);
        clk_1s = 1'b1;
        cycle();
        clk_1s = 1'b0;
        apply_reset();
        repeat (4) cycle();
        check_eq("t5_cleared", sec_bcd, 8'h00);
        pulse_1s(3, 3);
        check_eq("t5_resume", sec_bcd, 8'h01);

`ifdef BCD_ALARM_EN
        // 6: alarm fires on counting and holds until acknowledged
        alarm_set = 1'b1; alarm_hour = 8'h1A; alarm_min = 8'h00;
        cycle();
        alarm_set = 1'b0;
        check_eq("t6_bad_alarm", load_err, 1);
        alarm_set = 1'b1; alarm_hour = 8'h00; alarm_min = 8'h02;
        cycle();
        alarm_set = 1'b0;
        do_load(8'h00, 8'h01, 8'h58);
        pulse_1s(3, 3);
        check_eq("t6_not_yet", alarm, 0);
        pulse_1s(3, 3);
        check_eq("t6_fire", alarm, 1);
        pulse_1s(3, 3);
        check_eq("t6_hold", alarm, 1);
        alarm_ack = 1'b1;
        cycle();
        alarm_ack = 1'b0;
        check_eq("t6_ack", alarm, 0);
        do_load(8'h00, 8'h02, 8'h00);
        cycle();
        check_eq("t6_load_nofire", alarm, 0);
`endif

        // Randomized traffic
        do_load(8'h23, 8'h58, 8'h30);
        ph = 3;
        repeat (2000) begin
            ph--;
            if (ph == 0) begin
                clk_1s = ~clk_1s;
                ph = $urandom_range(2, 8);
            end
            run  = ($urandom_range(0, 9) != 0);
            load = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1) begin
                set_hour = to_bcd($urandom_range(0, HM));
                set_min  = to_bcd($urandom_range(0, 59));
                set_sec  = to_bcd($urandom_range(0, 59));
            end else begin
                set_hour = 8'($urandom);
                set_min  = 8'($urandom);
                set_sec  = 8'($urandom);
            end
            cycle();
            load = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
